// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiplier/divider: issues init pulses, waits for stop, loads HI/LO.
// Flags divide-by-zero and watchdog timeout; stalls MFHI/MFLO while an operation is in flight.
module muldiv_sequencer #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic clk,
  input  logic reset_in,
  input  logic start_mult,
  input  logic start_div,
  input  logic hilo_read,
  input  logic mult_stop,
  input  logic div_stop,
  input  logic div_zero,
  output logic mult_init,
  output logic div_init,
  output logic mux_high,
  output logic mux_low,
  output logic high_load,
  output logic low_load,
  output logic busy,
  output logic stall,
  output logic done,
  output logic div0_exc,
  output logic timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_M_INIT, S_M_WAIT, S_D_INIT, S_D_WAIT, S_WRITE, S_DIV0, S_TOUT
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sel;
  logic             w_cnt_max;

  assign w_cnt_max = (r_cnt == LP_CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset_in) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Wait counter and unit-select flag; the flag persists so the HI/LO muxes stay stable.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      r_cnt <= '0;
      r_sel <= 1'b0;
    end else begin
      case (r_state)
        S_M_INIT: begin
          r_cnt <= '0;
          r_sel <= 1'b0;
        end
        S_D_INIT: begin
          r_cnt <= '0;
          r_sel <= 1'b1;
        end
        S_M_WAIT, S_D_WAIT: r_cnt <= r_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_mult)     w_next = S_M_INIT;
        else if (start_div) w_next = S_D_INIT;
      end
      S_M_INIT: w_next = S_M_WAIT;
      S_D_INIT: w_next = S_D_WAIT;
      S_M_WAIT: begin
        if (mult_stop)      w_next = S_WRITE;
        else if (w_cnt_max) w_next = S_TOUT;
      end
      S_D_WAIT: begin
        if (div_zero)       w_next = S_DIV0;
        else if (div_stop)  w_next = S_WRITE;
        else if (w_cnt_max) w_next = S_TOUT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mult_init   = 1'b0;
    div_init    = 1'b0;
    high_load   = 1'b0;
    low_load    = 1'b0;
    done        = 1'b0;
    div0_exc    = 1'b0;
    timeout_err = 1'b0;
    case (r_state)
      S_M_INIT: mult_init = 1'b1;
      S_D_INIT: div_init  = 1'b1;
      S_WRITE: begin
        high_load = 1'b1;
        low_load  = 1'b1;
        done      = 1'b1;
      end
      S_DIV0:  div0_exc    = 1'b1;
      S_TOUT:  timeout_err = 1'b1;
      default: ;
    endcase
  end

  assign mux_high = r_sel;
  assign mux_low  = r_sel;
  assign busy     = (r_state != S_IDLE);
  // HI/LO are written at the end of WRITE, so MFHI/MFLO may proceed only from IDLE.
  assign stall    = hilo_read & busy;

endmodule
